// File: rtl/uart_cmd_decoder_if.sv
// Drive-command link signals between the UART decoder and its host.
// slave: decoder side, master: line driver / output consumer side.
interface uart_cmd_decoder_if;
  logic       uart_in;
  logic [3:0] move_cmd;
  logic [3:0] speed_level;
  logic       cmd_valid;
  logic       frame_err;
  logic       link_ok;

  modport slave (
    input  uart_in,
    output move_cmd, speed_level, cmd_valid, frame_err, link_ok
  );

  modport master (
    output uart_in,
    input  move_cmd, speed_level, cmd_valid, frame_err, link_ok
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART 8N1 receiver plus SYNC/PAYLOAD/CHECK frame decoder for motor commands.
// A watchdog forces STOP when valid frames cease, so a lost link halts the car.
module uart_cmd_decoder #(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [3:0]  STOP_CMD       = 4'b1000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_decoder_if.slave  bus
);

  localparam int unsigned BIT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IB_LIMIT = 20 * CLKS_PER_BIT;
  localparam int unsigned IB_W     = $clog2(IB_LIMIT + 1);
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] F_SYNC    = 2'd0;
  localparam logic [1:0] F_PAYLOAD = 2'd1;
  localparam logic [1:0] F_CHECK   = 2'd2;

  logic             r_sync1, r_sync2;
  logic [1:0]       r_bit_state, w_bit_state_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [1:0]       r_frm_state, w_frm_state_nxt;
  logic [7:0]       r_payload, w_payload_nxt;
  logic [IB_W-1:0]  r_ib_cnt, w_ib_cnt_nxt;
  logic [WD_W-1:0]  r_wd, w_wd_nxt;
  logic [3:0]       r_move, w_move_nxt;
  logic [3:0]       r_speed, w_speed_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_link_ok, w_link_ok_nxt;

  logic w_rx, w_byte_done, w_stop_err, w_accept, w_reject;

  assign w_rx = r_sync2;

  // Bit-level receiver: mid-bit sampling timed from the start-bit midpoint.
  always_comb begin
    w_bit_state_nxt = r_bit_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_byte_done     = 1'b0;
    w_stop_err      = 1'b0;
    case (r_bit_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_bit_state_nxt = S_START;
          w_bit_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_bit_cnt == BIT_W'(CLKS_PER_BIT / 2)) begin
          w_bit_cnt_nxt   = '0;
          w_bit_idx_nxt   = 3'd0;
          w_bit_state_nxt = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        end
      end
      S_DATA: begin
        if (r_bit_cnt == BIT_W'(CLKS_PER_BIT - 1)) begin
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = {w_rx, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_bit_state_nxt = S_STOP;
          else                   w_bit_idx_nxt   = r_bit_idx + 3'd1;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        end
      end
      S_STOP: begin
        if (r_bit_cnt == BIT_W'(CLKS_PER_BIT - 1)) begin
          w_byte_done     = w_rx;
          w_stop_err      = !w_rx;
          w_bit_cnt_nxt   = '0;
          w_bit_state_nxt = S_IDLE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        end
      end
      default: w_bit_state_nxt = S_IDLE;
    endcase
  end

  // Frame assembly with inter-byte timeout back to sync hunting.
  always_comb begin
    w_frm_state_nxt = r_frm_state;
    w_payload_nxt   = r_payload;
    w_ib_cnt_nxt    = '0;
    w_accept        = 1'b0;
    w_reject        = 1'b0;
    case (r_frm_state)
      F_SYNC: begin
        if (w_byte_done && (r_shift == SYNC_BYTE)) w_frm_state_nxt = F_PAYLOAD;
      end
      F_PAYLOAD, F_CHECK: begin
        if (w_byte_done) begin
          if (r_frm_state == F_PAYLOAD) begin
            w_payload_nxt   = r_shift;
            w_frm_state_nxt = F_CHECK;
          end else begin
            w_accept        = (r_shift == ~r_payload) && (r_payload[3:0] <= STOP_CMD);
            w_reject        = !w_accept;
            w_frm_state_nxt = F_SYNC;
          end
        end else if (w_stop_err || (r_ib_cnt == IB_W'(IB_LIMIT - 1))) begin
          w_frm_state_nxt = F_SYNC;
        end else begin
          w_ib_cnt_nxt = r_ib_cnt + IB_W'(1);
        end
      end
      default: w_frm_state_nxt = F_SYNC;
    endcase
  end

  // Output registers and watchdog; an accept overrides a same-cycle expiry.
  always_comb begin
    w_move_nxt      = r_move;
    w_speed_nxt     = r_speed;
    w_link_ok_nxt   = r_link_ok;
    w_cmd_valid_nxt = w_accept;
    w_frame_err_nxt = w_stop_err | w_reject;
    if (w_accept)                             w_wd_nxt = '0;
    else if (r_wd == WD_W'(TIMEOUT_CYCLES))   w_wd_nxt = r_wd;
    else                                      w_wd_nxt = r_wd + WD_W'(1);
    if (w_accept) begin
      w_move_nxt    = r_payload[3:0];
      w_speed_nxt   = r_payload[7:4];
      w_link_ok_nxt = 1'b1;
    end else if (w_wd_nxt == WD_W'(TIMEOUT_CYCLES)) begin
      w_move_nxt    = STOP_CMD;
      w_speed_nxt   = 4'd0;
      w_link_ok_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_bit_state <= S_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_frm_state <= F_SYNC;
      r_payload   <= 8'd0;
      r_ib_cnt    <= '0;
      r_wd        <= '0;
      r_move      <= STOP_CMD;
      r_speed     <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_link_ok   <= 1'b0;
    end else begin
      r_sync1     <= bus.uart_in;
      r_sync2     <= r_sync1;
      r_bit_state <= w_bit_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_frm_state <= w_frm_state_nxt;
      r_payload   <= w_payload_nxt;
      r_ib_cnt    <= w_ib_cnt_nxt;
      r_wd        <= w_wd_nxt;
      r_move      <= w_move_nxt;
      r_speed     <= w_speed_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_link_ok   <= w_link_ok_nxt;
    end
  end

  assign bus.move_cmd    = r_move;
  assign bus.speed_level = r_speed;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.link_ok     = r_link_ok;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed frame table, hand-written corner sequences,
// then random frames scored against a frame-level reference model.
module tb_uart_cmd_decoder;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_decoder_if intf ();

  uart_cmd_decoder #(
    .CLKS_PER_BIT  (CPB),
    .SYNC_BYTE     (8'hA5),
    .STOP_CMD      (4'b1000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    bit         bad_stop;
    int         exp_valid, exp_err, exp_move, exp_speed, exp_link;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_valid_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Pulse monitor: counts high cycles and flags simultaneous pulses.
  always @(negedge clk) begin
    if (intf.cmd_valid || intf.frame_err) begin
      n_checks++;
      if (intf.cmd_valid && intf.frame_err) begin
        n_errors++;
        $display("FAIL pulse_overlap: cmd_valid=1 frame_err=1 at cycle %0d, required at most one", cyc);
      end
    end
    if (intf.cmd_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (intf.frame_err) n_err++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    intf.uart_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_val);
    drive_bit(1'b1);
  endtask

  // Sends a frame; bad_stop corrupts the stop bit of the third byte.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit bad_stop);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, !bad_stop);
  endtask

  task automatic check_outputs(input string tag, input int mv, input int sp, input int lk);
    check({tag, "_move"},  int'(intf.move_cmd),    mv);
    check({tag, "_speed"}, int'(intf.speed_level), sp);
    check({tag, "_link"},  int'(intf.link_ok),     lk);
  endtask

  vec_t tbl[7];

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int v0, e0;
    logic [7:0] b1, b2;
    bit bad, acc;
    int m_move, m_speed, m_link;

    tbl[0] = '{8'hA5, 8'h31, 8'hCE, 1'b0, 1, 0, 1, 3, 1};
    tbl[1] = '{8'hA5, 8'h31, 8'hCF, 1'b0, 0, 1, 1, 3, 1};
    tbl[2] = '{8'hA5, 8'h09, 8'hF6, 1'b0, 0, 1, 1, 3, 1};
    tbl[3] = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 1, 0, 5, 10, 1};
    tbl[4] = '{8'hA5, 8'h12, 8'hED, 1'b1, 0, 1, 5, 10, 1};
    tbl[5] = '{8'h3C, 8'h41, 8'hBE, 1'b0, 0, 0, 5, 10, 1};
    tbl[6] = '{8'hA5, 8'h78, 8'h87, 1'b0, 1, 0, 8, 7, 1};

    intf.uart_in = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_outputs("reset", 8, 0, 0);
    check("reset_pulses", n_valid + n_err, 0);

    for (int i = 0; i < 7; i++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].bad_stop);
      check($sformatf("vec%0d_valid", i), n_valid - v0, tbl[i].exp_valid);
      check($sformatf("vec%0d_err", i),   n_err - e0,   tbl[i].exp_err);
      check_outputs($sformatf("vec%0d", i), tbl[i].exp_move, tbl[i].exp_speed, tbl[i].exp_link);
    end

    // Lone byte with a bad stop bit, then a valid frame.
    v0 = n_valid; e0 = n_err;
    send_byte(8'h33, 1'b0);
    check("badstop_err", n_err - e0, 1);
    check("badstop_valid", n_valid - v0, 0);
    check_outputs("badstop", 8, 7, 1);
    send_frame(8'hA5, 8'h20, 8'hDF, 1'b0);
    check("after_badstop_valid", n_valid - v0, 1);
    check_outputs("after_badstop", 0, 2, 1);

    // Watchdog: link must survive 1999 cycles after the accept and drop at 2000.
    e0 = n_err; v0 = n_valid;
    while (cyc < last_valid_cyc + int'(TMO) - 1) @(negedge clk);
    check_outputs("wd_before", 0, 2, 1);
    @(negedge clk);
    check_outputs("wd_expire", 8, 0, 0);
    check("wd_pulses", (n_valid - v0) + (n_err - e0), 0);

    // One-cycle low glitch on the idle line.
    v0 = n_valid; e0 = n_err;
    intf.uart_in = 1'b0;
    @(negedge clk);
    intf.uart_in = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);
    check_outputs("glitch", 8, 0, 0);

    // Reset in the middle of a data byte after a valid command.
    send_frame(8'hA5, 8'h31, 8'hCE, 1'b0);
    check_outputs("pre_rst", 1, 3, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    intf.uart_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("mid_rst", 8, 0, 0);

    // Random frames against the frame-level model; every 4th frame is legal.
    m_move = 8; m_speed = 0; m_link = 0;
    for (int i = 0; i < 24; i++) begin
      b1  = 8'($urandom_range(0, 255));
      bad = 1'b0;
      if (i % 4 == 0) begin
        b1[3:0] = 4'($urandom_range(0, 8));
        b2 = ~b1;
      end else begin
        case ($urandom_range(0, 2))
          0: b2 = ~b1;
          1: b2 = 8'($urandom_range(0, 255));
          default: begin b2 = ~b1; bad = 1'b1; end
        endcase
      end
      acc = !bad && (b2 == ~b1) && (b1[3:0] <= 4'd8);
      if (acc) begin
        m_move = int'(b1[3:0]); m_speed = int'(b1[7:4]); m_link = 1;
      end
      v0 = n_valid; e0 = n_err;
      send_frame(8'hA5, b1, b2, bad);
      check($sformatf("rnd%0d_valid", i), n_valid - v0, acc ? 1 : 0);
      check($sformatf("rnd%0d_err", i),   n_err - e0,   acc ? 0 : 1);
      check_outputs($sformatf("rnd%0d", i), m_move, m_speed, m_link);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
